fp_exp_align: RTL and testbench
===============================

// Module: fp_exp_align
// PURPOSE
//  Upstream stage of the FP add/sub sign logic. Takes two unpacked operands,
//  compares exponents, picks the larger operand and right-shifts the smaller
//  mantissa into alignment one bit per cycle, collecting a sticky bit.
//  Outputs exp_diffsig, mant_diffsig and exp_diff in the form the sign-decision
//  stage consumes. Aligned mantissas go to the add/sub datapath.
//  Valid/ready on both sides; one operation in flight at a time.
// PARAMETERS
//  EXP_W   4  exponent width; exp_diff is EXP_W bits
//  MANT_W  8  mantissa width, hidden bit included (MSB)
// PORTS
//  clk                 in   1       rising-edge clock
//  rst_n               in   1       asynchronous, active-low reset
//  in_valid            in   1       operand pair valid
//  in_ready            out  1       block can accept (state IDLE)
//  sign_A, sign_B      in   1       operand signs
//  exp_A, exp_B        in   EXP_W   operand exponents (unsigned)
//  mant_A, mant_B      in   MANT_W  operand mantissas
//  out_valid           out  1       aligned result valid
//  out_ready           in   1       downstream accepts
//  exp_diffsig         out  1       1 => exp_A < exp_B
//  mant_diffsig        out  1       1 => mant_A < mant_B (raw, unshifted)
//  exp_diff            out  EXP_W   |exp_A - exp_B|
//  exp_big             out  EXP_W   larger exponent (result exponent)
//  mant_big            out  MANT_W  mantissa of larger-exponent operand
//  mant_small          out  MANT_W  aligned mantissa of the other operand
//  sticky              out  1       OR of all bits shifted out of mant_small
//  sign_A_o, sign_B_o  out  1       registered copies of sign_A, sign_B
// BEHAVIOUR
//  Reset: state IDLE, every output register 0, counter 0. in_ready = (state==IDLE),
//   so in_ready=1 during and after reset. Reset mid-operation discards the op.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: on in_valid&in_ready, register all fields.
//   Swap rule: exp_A>=exp_B => big=A, small=B. Otherwise big=B, small=A.
//   Equal exponents => big=A.
//   mant_diffsig = mant_A<mant_B; exp_diff = |exp_A-exp_B| (EXP_W bits, no overflow).
//   cnt <= exp_diff. Next state: DONE if exp_diff==0, else SHIFT.
//  SHIFT, cnt>MANT_W (saturate): mant_small<=0, sticky<=|mant_small, go DONE (1 cycle).
//  SHIFT, otherwise: each cycle mant_small<=mant_small>>1, sticky|=mant_small[0],
//   cnt<=cnt-1. Go DONE on the cycle cnt reaches 1 (that cycle still shifts).
//  Latency, accept edge to out_valid: 1 cycle if D==0; D+1 if 1<=D<=MANT_W; 2 if D>MANT_W.
//  DONE: out_valid=1. All outputs held stable until out_valid&out_ready.
//   On that edge go IDLE and clear out_valid. in_ready rises on the next cycle.
//   No same-cycle accept/emit.
//  in_valid is ignored outside IDLE. Output fields keep their last values in IDLE.
// CONFIGURATION
//  FP_ALIGN_BARREL_EN defined: SHIFT is a single-cycle barrel shift by min(cnt,MANT_W+1).
//   Sticky = OR of all bits dropped. Latency is 1 if D==0, else 2.
//   Outputs are identical to the serial build.
//  Not defined: serial 1-bit/cycle shifter as above (default, smaller area).
// TESTING
//  1 exp_A=5 mant_A=C0, exp_B=3 mant_B=A0 -> diffsig=0 diff=2 exp_big=5 mant_big=C0
//    mant_small=28 sticky=0; out_valid 3 cycles after accept (2 in barrel build).
//  2 exp_A=2 mant_A=81, exp_B=7 mant_B=F0 -> diffsig=1 diff=5 exp_big=7 mant_big=F0
//    mant_small=04 sticky=1 mant_diffsig=1; latency 6 cycles.
//  3 exp_A=exp_B=4, mant_A=90 mant_B=A0 -> diff=0 diffsig=0 mant_diffsig=1
//    mant_big=90 mant_small=A0 sticky=0; latency 1 cycle.
//  4 exp_A=14 exp_B=2 mant_B=01 -> diff=12 mant_small=00 sticky=1; latency 2 cycles.
//  5 hold out_ready=0 for 4 cycles in DONE with in_valid=1 -> outputs stable,
//    in_ready=0, nothing accepted; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
//  6 rst_n low mid-SHIFT (case 2) -> all outputs 0 asynchronously, in_ready=1;
//    after release, case 1 completes with the values in test 1.

Source files
------------

// File: rtl/fp_exp_align.sv
// fp_exp_align: exponent compare and mantissa alignment ahead of the FP add/sub
// sign-decision stage. Picks the larger-exponent operand, right-shifts the other
// mantissa by the exponent difference and collects a sticky bit. One op in flight.
// Optional feature: define FP_ALIGN_BARREL_EN to replace the serial 1-bit/cycle
// shifter with a single-cycle barrel shift (same outputs, shorter latency).
module fp_exp_align #(
  parameter int unsigned EXP_W  = 4,
  parameter int unsigned MANT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_A,
  input  logic              sign_B,
  input  logic [EXP_W-1:0]  exp_A,
  input  logic [EXP_W-1:0]  exp_B,
  input  logic [MANT_W-1:0] mant_A,
  input  logic [MANT_W-1:0] mant_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              exp_diffsig,
  output logic              mant_diffsig,
  output logic [EXP_W-1:0]  exp_diff,
  output logic [EXP_W-1:0]  exp_big,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              sticky,
  output logic              sign_A_o,
  output logic              sign_B_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [EXP_W-1:0]    cnt_q, cnt_d;
  logic                exp_diffsig_q, exp_diffsig_d;
  logic                mant_diffsig_q, mant_diffsig_d;
  logic [EXP_W-1:0]    exp_diff_q, exp_diff_d;
  logic [EXP_W-1:0]    exp_big_q, exp_big_d;
  logic [MANT_W-1:0]   mant_big_q, mant_big_d;
  logic [MANT_W-1:0]   mant_small_q, mant_small_d;
  logic                sticky_q, sticky_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;

  logic                a_ge_b;
  logic [EXP_W-1:0]    diff_in;
  logic                cnt_sat;

  assign a_ge_b  = (exp_A >= exp_B);
  assign diff_in = a_ge_b ? (exp_A - exp_B) : (exp_B - exp_A);
  // Shifting by more than MANT_W leaves nothing but sticky, so finish in one step.
  assign cnt_sat = (32'(cnt_q) > MANT_W);

`ifdef FP_ALIGN_BARREL_EN
  logic [31:0]         shamt;
  logic [2*MANT_W:0]   shift_ext;

  // Barrel shift into a widened vector; the low MANT_W+1 bits are what fell off.
  always_comb begin
    shamt     = cnt_sat ? 32'(MANT_W + 1) : 32'(cnt_q);
    shift_ext = {mant_small_q, {(MANT_W + 1){1'b0}}} >> shamt;
  end
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    exp_diffsig_d  = exp_diffsig_q;
    mant_diffsig_d = mant_diffsig_q;
    exp_diff_d     = exp_diff_q;
    exp_big_d      = exp_big_q;
    mant_big_d     = mant_big_q;
    mant_small_d   = mant_small_q;
    sticky_d       = sticky_q;
    sign_a_d       = sign_a_q;
    sign_b_d       = sign_b_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Equal exponents keep A as the big operand.
          exp_diffsig_d  = ~a_ge_b;
          mant_diffsig_d = (mant_A < mant_B);
          exp_diff_d     = diff_in;
          exp_big_d      = a_ge_b ? exp_A : exp_B;
          mant_big_d     = a_ge_b ? mant_A : mant_B;
          mant_small_d   = a_ge_b ? mant_B : mant_A;
          sticky_d       = 1'b0;
          sign_a_d       = sign_A;
          sign_b_d       = sign_B;
          cnt_d          = diff_in;
          state_d        = (diff_in == '0) ? StDone : StShift;
        end
      end
      StShift: begin
`ifdef FP_ALIGN_BARREL_EN
        mant_small_d = shift_ext[2*MANT_W -: MANT_W];
        sticky_d     = sticky_q | (|shift_ext[MANT_W:0]);
        cnt_d        = '0;
        state_d      = StDone;
`else
        if (cnt_sat) begin
          mant_small_d = '0;
          sticky_d     = sticky_q | (|mant_small_q);
          cnt_d        = '0;
          state_d      = StDone;
        end else begin
          mant_small_d = mant_small_q >> 1;
          sticky_d     = sticky_q | mant_small_q[0];
          cnt_d        = cnt_q - EXP_W'(1);
          if (cnt_q == EXP_W'(1)) begin
            state_d = StDone;
          end
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      exp_diffsig_q  <= 1'b0;
      mant_diffsig_q <= 1'b0;
      exp_diff_q     <= '0;
      exp_big_q      <= '0;
      mant_big_q     <= '0;
      mant_small_q   <= '0;
      sticky_q       <= 1'b0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exp_diffsig_q  <= exp_diffsig_d;
      mant_diffsig_q <= mant_diffsig_d;
      exp_diff_q     <= exp_diff_d;
      exp_big_q      <= exp_big_d;
      mant_big_q     <= mant_big_d;
      mant_small_q   <= mant_small_d;
      sticky_q       <= sticky_d;
      sign_a_q       <= sign_a_d;
      sign_b_q       <= sign_b_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign exp_diffsig  = exp_diffsig_q;
  assign mant_diffsig = mant_diffsig_q;
  assign exp_diff     = exp_diff_q;
  assign exp_big      = exp_big_q;
  assign mant_big     = mant_big_q;
  assign mant_small   = mant_small_q;
  assign sticky       = sticky_q;
  assign sign_A_o     = sign_a_q;
  assign sign_B_o     = sign_b_q;

endmodule

// File: tb/tb_fp_exp_align.sv
// Self-checking bench for fp_exp_align: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_fp_exp_align;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MANT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              sign_A, sign_B;
  logic [EXP_W-1:0]  exp_A, exp_B;
  logic [MANT_W-1:0] mant_A, mant_B;
  logic              out_valid;
  logic              out_ready;
  logic              exp_diffsig;
  logic              mant_diffsig;
  logic [EXP_W-1:0]  exp_diff;
  logic [EXP_W-1:0]  exp_big;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W-1:0] mant_small;
  logic              sticky;
  logic              sign_A_o, sign_B_o;

  fp_exp_align #(
    .EXP_W (EXP_W),
    .MANT_W(MANT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_A      (sign_A),
    .sign_B      (sign_B),
    .exp_A       (exp_A),
    .exp_B       (exp_B),
    .mant_A      (mant_A),
    .mant_B      (mant_B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .exp_diffsig (exp_diffsig),
    .mant_diffsig(mant_diffsig),
    .exp_diff    (exp_diff),
    .exp_big     (exp_big),
    .mant_big    (mant_big),
    .mant_small  (mant_small),
    .sticky      (sticky),
    .sign_A_o    (sign_A_o),
    .sign_B_o    (sign_B_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int diffsig;
    int mdiffsig;
    int diff;
    int ebig;
    int mbig;
    int msmall;
    int sticky;
    int sa;
    int sb;
    int lat;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: alignment as plain integer division/remainder by 2^D.
  function automatic exp_t model(int sa, int sb, int ea, int eb, int ma, int mb);
    exp_t e;
    int   small_m;
    int   d;
    if (ea >= eb) begin
      e.ebig = ea; e.mbig = ma; small_m = mb; d = ea - eb;
    end else begin
      e.ebig = eb; e.mbig = mb; small_m = ma; d = eb - ea;
    end
    e.diffsig  = (ea < eb) ? 1 : 0;
    e.mdiffsig = (ma < mb) ? 1 : 0;
    e.diff     = d;
    if (d >= int'(MANT_W)) begin
      e.msmall = 0;
      e.sticky = (small_m != 0) ? 1 : 0;
    end else begin
      e.msmall = small_m / (1 << d);
      e.sticky = ((small_m % (1 << d)) != 0) ? 1 : 0;
    end
    if (d == 0) e.lat = 1;
`ifdef FP_ALIGN_BARREL_EN
    else e.lat = 2;
`else
    else if (d <= int'(MANT_W)) e.lat = d + 1;
    else e.lat = 2;
`endif
    e.sa = sa;
    e.sb = sb;
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    chk({tag, ".exp_diffsig"}, exp_diffsig, e.diffsig);
    chk({tag, ".mant_diffsig"}, mant_diffsig, e.mdiffsig);
    chk({tag, ".exp_diff"}, exp_diff, e.diff);
    chk({tag, ".exp_big"}, exp_big, e.ebig);
    chk({tag, ".mant_big"}, mant_big, e.mbig);
    chk({tag, ".mant_small"}, mant_small, e.msmall);
    chk({tag, ".sticky"}, sticky, e.sticky);
    chk({tag, ".sign_A_o"}, sign_A_o, e.sa);
    chk({tag, ".sign_B_o"}, sign_B_o, e.sb);
  endtask

  // Present an op, count cycles from the accept edge until out_valid, check results.
  task automatic do_op(input string tag, input int sa, input int sb, input int ea,
                       input int eb, input int ma, input int mb, output exp_t e);
    int lat;
    e = model(sa, sb, ea, eb, ma, mb);
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    sign_A   = sa[0];
    sign_B   = sb[0];
    exp_A    = EXP_W'(ea);
    exp_B    = EXP_W'(eb);
    mant_A   = MANT_W'(ma);
    mant_B   = MANT_W'(mb);
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 64);
    chk({tag, ".latency"}, lat, e.lat);
    check_fields(tag, e);
  endtask

  // Complete the output handshake and check the return to idle.
  task automatic drain(input string tag, input exp_t e);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drain.out_valid"}, out_valid, 0);
    chk({tag, ".drain.in_ready"}, in_ready, 1);
    check_fields({tag, ".idle_hold"}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t z;
    z = '{default: 0};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_A    = 1'b0;
    sign_B    = 1'b0;
    exp_A     = '0;
    exp_B     = '0;
    mant_A    = '0;
    mant_B    = '0;

    // Reset state
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    check_fields("rst", z);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op("t1", 0, 1, 5, 3, 'hC0, 'hA0, e);
    drain("t1", e);
    do_op("t2", 1, 0, 2, 7, 'h81, 'hF0, e);
    drain("t2", e);
    do_op("t3", 0, 0, 4, 4, 'h90, 'hA0, e);
    drain("t3", e);
    do_op("t4", 1, 1, 14, 2, 'h80, 'h01, e);
    drain("t4", e);
    do_op("shift8", 0, 1, 9, 1, 'hFF, 'h81, e);
    drain("shift8", e);

    // Back-pressure in DONE with a competing in_valid
    do_op("t5", 1, 0, 6, 3, 'hB5, 'h9F, e);
    sign_A   = 1'b0;
    exp_A    = 4'd1;
    exp_B    = 4'd15;
    mant_A   = 8'h11;
    mant_B   = 8'h22;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5.stall.out_valid", out_valid, 1);
      chk("t5.stall.in_ready", in_ready, 0);
      check_fields("t5.stall", e);
    end
    in_valid = 1'b0;
    drain("t5", e);

    // Reset in the middle of a shift
    e = model(1, 0, 2, 7, 'h81, 'hF0);
    @(negedge clk);
    sign_A   = 1'b1;
    sign_B   = 1'b0;
    exp_A    = 4'd2;
    exp_B    = 4'd7;
    mant_A   = 8'h81;
    mant_B   = 8'hF0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6.pre.out_valid", out_valid, 0);
    chk("t6.pre.exp_big", exp_big, e.ebig);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.rst.in_ready", in_ready, 1);
    chk("t6.rst.out_valid", out_valid, 0);
    check_fields("t6.rst", z);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("t6.after", 0, 1, 5, 3, 'hC0, 'hA0, e);
    drain("t6.after", e);

    // Random operands with random output stalls
    for (int i = 0; i < 40; i++) begin
      int sa, sb, ea, eb, ma, mb;
      sa = int'($urandom_range(0, 1));
      sb = int'($urandom_range(0, 1));
      ea = int'($urandom_range(0, 15));
      eb = int'($urandom_range(0, 15));
      ma = int'($urandom_range(0, 255));
      mb = int'($urandom_range(0, 255));
      do_op("rand", sa, sb, ea, eb, ma, mb, e);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rand.stall.out_valid", out_valid, 1);
        chk("rand.stall.mant_small", mant_small, e.msmall);
      end
      drain("rand", e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
